obi_mem_responder: RTL

- OBI slave endpoint with fixed, configurable latency, backed by an internal word-addressed memory.
- Connects to one slave_req_o/slave_resp_i pair of the system crossbar. It issues gnt and returns in-order rvalid/rdata.
- Throttles gnt by an outstanding-transaction limit and an external stall input.
- Serves as the responder for integration and crossbar verification, and as a scratchpad bank.

---
 rtl/cei_mochila_pkg.sv | 27 ++
 rtl/obi_pkg.sv | 19 +
 rtl/obi_resp_pipe.sv | 34 +++
 rtl/obi_mem_responder.sv | 104 ++++++++++
 4 files changed

// File: rtl/cei_mochila_pkg.sv
// Shared constants and bundles for the cei_mochila SoC slice.
// Holds the memory-responder pipeline entry and its error pattern.
package cei_mochila_pkg;

  localparam logic [31:0] MEM_RESP_ERR_RDATA = 32'hBADC_AB1E;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } resp_pipe_entry_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by initiators, crossbar and responders.
// Single-channel variant: no atop/aid/err sideband.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-depth response shift register; one stage per cycle, no backpressure.
// Idle entries carry zero data so rdata is 0 whenever valid is 0.
module obi_resp_pipe
  import cei_mochila_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  resp_pipe_entry_t in_entry,
  output logic             out_valid,
  output logic [31:0]      out_rdata
);

  resp_pipe_entry_t stage_q [LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_entry;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_rdata = stage_q[LATENCY-1].valid ?
                     stage_q[LATENCY-1].rdata : '0;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory endpoint with fixed response latency and outstanding limit.
// Grant is throttled by the slot count and an external stall input.
module obi_mem_responder
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = MEM_RESP_ERR_RDATA,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  obi_req_t        slave_req_i,
  output obi_resp_t       slave_resp_o,
  input  logic            stall_i,
  output logic [CW-1:0]   outstanding_o,
  output logic            oob_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN = 32'(NUM_WORDS * 4);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [31:0]      mem_q [NUM_WORDS];
  logic [31:0]      off;
  logic             in_range;
  logic [AW-1:0]    idx;
  logic             gnt;
  logic             rvalid;
  logic [31:0]      rdata;
  logic [CW-1:0]    cnt_q;
  logic             oob_q;
  resp_pipe_entry_t in_entry;

  assign off      = slave_req_i.addr - BASE_ADDR;
  assign in_range = off < SPAN;
  assign idx      = off[AW+1:2];

  // Slot freed by rvalid only becomes usable next cycle.
  assign gnt = slave_req_i.req & ~stall_i &
               (cnt_q < MAX_CNT) & ~rst_i;

  always_comb begin
    in_entry = '0;
    if (gnt) begin
      in_entry.valid = 1'b1;
      if (!slave_req_i.we) begin
        in_entry.rdata = in_range ? mem_q[idx] : ERR_RDATA;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt && slave_req_i.we && in_range) begin
      mem_q[idx] <= be_merge(mem_q[idx],
                             slave_req_i.wdata,
                             slave_req_i.be);
    end
  end

  obi_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_entry  (in_entry),
    .out_valid (rvalid),
    .out_rdata (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      oob_q <= 1'b0;
    end else begin
      oob_q <= gnt & ~in_range;
      unique case (1'b1)
        gnt && !rvalid: cnt_q <= cnt_q + CW'(1);
        rvalid && !gnt: cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    slave_resp_o        = '0;
    slave_resp_o.gnt    = gnt;
    slave_resp_o.rvalid = rvalid;
    slave_resp_o.rdata  = rdata;
  end

  assign outstanding_o = cnt_q;
  assign oob_o         = oob_q;

  a_cnt_max: assert property (
    @(posedge clk_i) disable iff (rst_i) cnt_q <= MAX_CNT);

  a_cnt_underflow: assert property (
    @(posedge clk_i) disable iff (rst_i) rvalid |-> (cnt_q != '0));

endmodule
